flit_send_arbiter: RTL and testbench

FLIT_SEND_ARBITER -- requirements
Module: flit_send_arbiter

---
 rtl/flit_arb_pkg.sv | 31 +++
 rtl/flit_send_arbiter_rr_picker.sv | 33 +++
 rtl/flit_send_arbiter.sv | 144 ++++++++++++++
 tb/tb_flit_send_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flit_arb_pkg.sv
// Shared definitions for the flit send arbiter: flit field positions, FSM states, credit sizing.
// Flit layout (MSB down): valid strobe, tail bit, VC field, payload.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef VC_BITS
`define VC_BITS 2
`endif
`ifndef FLIT_BUFFER_DEPTH
`define FLIT_BUFFER_DEPTH 4
`endif

package flit_arb_pkg;

  localparam int FLIT_W    = `FLIT_WIDTH;
  localparam int VC_W      = `VC_BITS;
  localparam int VALID_BIT = FLIT_W - 1;
  localparam int TAIL_BIT  = FLIT_W - 2;
  localparam int VC_LSB    = FLIT_W - 2 - VC_W;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // One extra bit so a counter can hold the full DEPTH value.
  function automatic int credit_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/flit_send_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    for (int off = 0; off < N; off++) begin
      if (!any_o) begin
        cand = int'(ptr_i) + off;
        if (cand >= N) cand = cand - N;
        if (req_i[IW'(cand)]) begin
          any_o               = 1'b1;
          grant_o[IW'(cand)]  = 1'b1;
          idx_o               = IW'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/flit_send_arbiter.sv
// Credit-based round-robin arbiter with packet locking onto one network send port.
// Optional stall counter enabled by defining FLIT_SEND_ARB_STALL_CNT_EN.
module flit_send_arbiter
  import flit_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_VCS = 2,
  parameter int DEPTH   = `FLIT_BUFFER_DEPTH
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [NUM_REQ-1:0][`FLIT_WIDTH-1:0] req_flit,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [`FLIT_WIDTH-1:0]              send_ports_putFlit_flit_in,
  output logic                                EN_send_ports_putFlit,
  input  logic [`VC_BITS:0]                   send_ports_getCredits,
  output logic                                EN_send_ports_getCredits,
  output logic                                credit_err,
  output logic [31:0]                         stall_cycles
);

  localparam int CW = credit_width(DEPTH);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  arb_state_e state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_VCS*CW-1:0] credit_q, credit_d;
  logic credit_err_q, credit_err_d;

  logic [(1<<VC_W)-1:0] vc_avail;
  logic [NUM_REQ-1:0] eligible, pick_req, grant;
  logic [IW-1:0] grant_idx;
  logic any_grant, send;
  logic [FLIT_W-1:0] sel_flit;
  logic sent_tail;
  logic [VC_W-1:0] sent_vc;
  logic ret_valid, ret_oor;
  logic [VC_W-1:0] ret_vc;
  logic [NUM_VCS-1:0] ovf;
  logic unused_sel_msb;

  assign ret_valid = send_ports_getCredits[VC_W];
  assign ret_vc    = send_ports_getCredits[VC_W-1:0];
  assign ret_oor   = ret_valid && (int'(ret_vc) >= NUM_VCS);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign eligible[gi] = req_valid[gi] && vc_avail[req_flit[gi][VC_LSB +: VC_W]];
  end

  // Send and return on the same VC cancel; a lone return at FULL is an overflow.
  for (genvar gi = 0; gi < NUM_VCS; gi++) begin : g_credit
    logic [CW-1:0] cur;
    logic snd, rt;
    assign cur = credit_q[gi*CW +: CW];
    assign snd = send && (sent_vc == VC_W'(gi));
    assign rt  = ret_valid && (ret_vc == VC_W'(gi));
    assign credit_d[gi*CW +: CW] = (snd && !rt)                 ? cur - 1'b1 :
                                   (rt && !snd && cur != FULL) ? cur + 1'b1 : cur;
    assign ovf[gi]      = rt && !snd && (cur == FULL);
    assign vc_avail[gi] = (cur != '0);
  end

  for (genvar gi = NUM_VCS; gi < (1 << VC_W); gi++) begin : g_vc_none
    assign vc_avail[gi] = 1'b0;
  end

  always_comb begin
    pick_req = eligible;
    if (state_q == LOCKED) pick_req = eligible & (NUM_REQ'(1) << owner_q);
  end

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_rr_picker (
    .req_i   (pick_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (any_grant)
  );

  assign req_ready             = (RST || !any_grant) ? '0 : grant;
  assign send                  = |(req_valid & req_ready);
  assign EN_send_ports_putFlit = send;
  assign sel_flit              = req_flit[grant_idx];
  assign sent_tail             = sel_flit[TAIL_BIT];
  assign sent_vc               = sel_flit[VC_LSB +: VC_W];
  assign unused_sel_msb        = sel_flit[VALID_BIT];
  assign send_ports_putFlit_flit_in = {send, sel_flit[VALID_BIT-1:0]};
  assign EN_send_ports_getCredits   = 1'b1;
  assign credit_err                 = credit_err_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    credit_err_d = credit_err_q | ret_oor | (|ovf);
    if (send) begin
      if (sent_tail) begin
        state_d  = IDLE;
        rr_ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        state_d = LOCKED;
        owner_d = grant_idx;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      credit_q     <= {NUM_VCS{FULL}};
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
    end
  end

`ifdef FLIT_SEND_ARB_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((|req_valid) && !send && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_flit_send_arbiter.sv
// Self-checking bench for flit_send_arbiter: directed scenarios plus a randomized run against a reference model.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef VC_BITS
`define VC_BITS 2
`endif
`ifndef FLIT_BUFFER_DEPTH
`define FLIT_BUFFER_DEPTH 4
`endif
`timescale 1ns/1ps
module tb_flit_send_arbiter;
  localparam int NR = 4, NV = 2, D = 4;
  localparam int FW = `FLIT_WIDTH, VB = `VC_BITS;
  localparam int TAILB = FW - 2, VCL = FW - 2 - VB;

  logic CLK = 1'b0;
  logic RST;
  logic [NR-1:0][FW-1:0] req_flit;
  logic [NR-1:0] req_valid, req_ready;
  logic [FW-1:0] flit_out;
  logic en_put, en_get, credit_err;
  logic [31:0] stall_cycles;
  logic [VB:0] ret;

  always #5 CLK = ~CLK;

  flit_send_arbiter #(.NUM_REQ(NR), .NUM_VCS(NV), .DEPTH(D)) dut (
    .CLK                        (CLK),
    .RST                        (RST),
    .req_flit                   (req_flit),
    .req_valid                  (req_valid),
    .req_ready                  (req_ready),
    .send_ports_putFlit_flit_in (flit_out),
    .EN_send_ports_putFlit      (en_put),
    .send_ports_getCredits      (ret),
    .EN_send_ports_getCredits   (en_get),
    .credit_err                 (credit_err),
    .stall_cycles               (stall_cycles)
  );

  int vectors = 0, miscompares = 0;
  int last_grant, n0;
  int exp_seq [5] = '{0, 1, 2, 3, 0};

  // Reference model state: packet lock, round-robin start, per-VC credits.
  bit m_locked;
  int m_owner, m_rr;
  int m_cred [NV];
  bit m_err;
  longint m_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int vc, input bit tail);
    logic [FW-1:0] f;
    f = FW'($urandom);
    f[TAILB] = tail;
    f[VCL +: VB] = VB'(vc);
    return f;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_rr     = 0;
    for (int v = 0; v < NV; v++) m_cred[v] = D;
    m_err    = 1'b0;
    m_stall  = 0;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NR; k++) begin
      int i;
      int vc;
      i  = (m_rr + k) % NR;
      vc = int'(req_flit[i][VCL +: VB]);
      if (m_locked && i != m_owner) continue;
      if (req_valid[i] && vc < NV && m_cred[vc] > 0) return i;
    end
    return -1;
  endfunction

  function automatic longint exp_stall();
`ifdef FLIT_SEND_ARB_STALL_CNT_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  // Called at posedge+1 with inputs already driven; checks, then advances one clock.
  task automatic cycle();
    int g, vc, rv;
    logic [NR-1:0] exp_rdy;
    logic [FW-1:0] ef;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    #3;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("en_put", 64'(en_put), 64'(g >= 0));
    if (g >= 0) begin
      ef = {1'b1, req_flit[g][FW-2:0]};
      check("flit_out", 64'(flit_out), 64'(ef));
    end else begin
      check("flit_msb", 64'(flit_out[FW-1]), 64'(0));
    end
    check("credit_err", 64'(credit_err), 64'(m_err));
    check("stall_cycles", 64'(stall_cycles), 64'(exp_stall()));
    check("en_get", 64'(en_get), 64'(1));
    last_grant = g;
    @(posedge CLK);
    #1;
    if (g >= 0) begin
      vc = int'(req_flit[g][VCL +: VB]);
      m_cred[vc] = m_cred[vc] - 1;
      if (req_flit[g][TAILB]) begin
        m_locked = 1'b0;
        m_rr = (g + 1) % NR;
      end else begin
        m_locked = 1'b1;
        m_owner = g;
      end
    end
    if (ret[VB]) begin
      rv = int'(ret[VB-1:0]);
      if (rv >= NV) m_err = 1'b1;
      else begin
        m_cred[rv] = m_cred[rv] + 1;
        if (m_cred[rv] > D) begin
          m_cred[rv] = D;
          m_err = 1'b1;
        end
      end
    end
    if ((|req_valid) && g < 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
  endtask

  // Asynchronous assert mid-cycle with requests pending; outputs must drop at once.
  task automatic do_reset();
    req_valid = '1;
    RST = 1'b1;
    #2;
    model_reset();
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_en", 64'(en_put), 64'(0));
    check("rst_msb", 64'(flit_out[FW-1]), 64'(0));
    check("rst_err", 64'(credit_err), 64'(0));
    check("rst_stall", 64'(stall_cycles), 64'(0));
    @(posedge CLK);
    #1;
    check("rst_hold_ready", 64'(req_ready), 64'(0));
    RST = 1'b0;
    req_valid = '0;
    ret = '0;
  endtask

  initial begin
    RST = 1'b1;
    ret = '0;
    req_valid = '1;
    for (int i = 0; i < NR; i++) req_flit[i] = mk(0, 1'b1);
    model_reset();
    #2;
    check("init_ready", 64'(req_ready), 64'(0));
    check("init_en", 64'(en_put), 64'(0));
    check("init_msb", 64'(flit_out[FW-1]), 64'(0));
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Round-robin across four single-flit requesters, credits returned every cycle.
    req_valid = '1;
    ret = {1'b1, VB'(0)};
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NR; i++) req_flit[i] = mk(0, 1'b1);
      cycle();
      check("rr_order", 64'(last_grant), 64'(exp_seq[c]));
    end

    // Three-flit packet from req1 holds the port while req2 waits.
    ret = '0;
    req_valid = 4'b0110;
    req_flit[2] = mk(0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      req_flit[1] = mk(0, c == 2);
      cycle();
      check("pkt_owner", 64'(last_grant), 64'(1));
    end
    req_valid = 4'b1101;
    for (int i = 0; i < NR; i++) req_flit[i] = mk(0, 1'b1);
    cycle();
    check("rr_after_pkt", 64'(last_grant), 64'(2));
    req_valid = '0;
    ret = {1'b1, VB'(0)};
    for (int c = 0; c < 4; c++) cycle();

    // VC0 exhaustion while a VC1 requester keeps flowing.
    req_valid = 4'b0011;
    n0 = 0;
    for (int c = 0; c < 12; c++) begin
      req_flit[0] = mk(0, 1'b1);
      req_flit[1] = mk(1, 1'b1);
      ret = (model_grant() == 1) ? {1'b1, VB'(1)} : '0;
      cycle();
      if (last_grant == 0) n0++;
    end
    check("vc0_sends", 64'(n0), 64'(4));
    ret = {1'b1, VB'(0)};
    cycle();
    ret = '0;
    cycle();
    check("vc0_resume", 64'(last_grant), 64'(0));

    // Lock owner 3, then reset mid-packet.
    req_valid = 4'b1000;
    req_flit[3] = mk(1, 1'b0);
    cycle();
    check("lock_owner3", 64'(last_grant), 64'(3));
    req_valid = '1;
    for (int i = 0; i < NR; i++) req_flit[i] = mk(0, 1'b1);
    req_flit[3] = mk(1, 1'b0);
    cycle();
    check("locked_only3", 64'(last_grant), 64'(3));
    do_reset();
    req_valid = '1;
    for (int i = 0; i < NR; i++) req_flit[i] = mk(0, 1'b1);
    cycle();
    check("post_reset_grant", 64'(last_grant), 64'(0));

    // Credit at 2: simultaneous send+return holds it, then only two more sends fit.
    req_valid = 4'b0001;
    req_flit[0] = mk(0, 1'b1);
    cycle();
    req_flit[0] = mk(0, 1'b1);
    ret = {1'b1, VB'(0)};
    cycle();
    ret = '0;
    n0 = 0;
    for (int c = 0; c < 3; c++) begin
      req_flit[0] = mk(0, 1'b1);
      cycle();
      if (last_grant == 0) n0++;
    end
    check("credit_2_hold", 64'(n0), 64'(2));
    req_valid = '0;
    ret = {1'b1, VB'(0)};
    for (int c = 0; c < 4; c++) cycle();
    check("no_err_at_full", 64'(credit_err), 64'(0));
    cycle();
    check("credit_err_ovf", 64'(credit_err), 64'(1));

    // Out-of-range VC return.
    do_reset();
    ret = {1'b1, VB'(2)};
    cycle();
    check("credit_err_oor", 64'(credit_err), 64'(1));
    ret = '0;

    // Stall counting with VC0 drained.
    do_reset();
    req_valid = 4'b0001;
    for (int c = 0; c < 14; c++) begin
      req_flit[0] = mk(0, 1'b1);
      cycle();
    end
`ifdef FLIT_SEND_ARB_STALL_CNT_EN
    check("stall_10", 64'(stall_cycles), 64'(10));
`else
    check("stall_off", 64'(stall_cycles), 64'(0));
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < 7);
        req_flit[i]  = mk($urandom_range(0, 1), $urandom_range(0, 9) < 4);
      end
      if ($urandom_range(0, 1) == 1)
        ret = {1'b1, ($urandom_range(0, 19) == 0) ? VB'(2) : VB'($urandom_range(0, 1))};
      else
        ret = '0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
